// File: rtl/fetch_buffer_pkg.sv
// Shared constants for the instruction fetch buffer and its queue.
package fetch_buffer_pkg;

    // PC value loaded on reset unless the instance overrides it.
    localparam logic [31:0] START_ADDRESS_DEFAULT = 32'h8002_0000;

    // Bytes per fetched instruction word; the PC advances by this amount.
    localparam int unsigned WORD_BYTES = 4;

    // Memory access size encoding for a single word.
    localparam logic [1:0] ACC_SIZE_WORD = 2'b00;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue: DEPTH entries, head/tail pointers, occupancy
// count and a flush that empties it in one cycle.
module fetch_queue
    import fetch_buffer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Pointer increment that wraps at DEPTH, so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Next-state for storage, pointers and count; flush overrides push/pop.
    always_comb begin
        mem_d     = mem_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        push_ok_s = push && (count_q != CNT_W'(DEPTH));
        pop_ok_s  = pop && (count_q != {CNT_W{1'b0}});
        if (flush) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_d[tail_q] = push_data;
                tail_d        = ptr_inc(tail_q);
            end else begin
                tail_d = tail_q;
            end
            if (pop_ok_s) begin
                head_d = ptr_inc(head_q);
            end else begin
                head_d = head_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues sequential word fetches under a credit
// limit, queues returned instructions for decode, and handles redirects by
// flushing the queue and discarding responses still in flight.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int                DATA_W        = 32,
    parameter int                ADDR_W        = 32,
    parameter int                DEPTH         = 4,
    parameter logic [ADDR_W-1:0] START_ADDRESS = ADDR_W'(START_ADDRESS_DEFAULT)
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_busy,
    output logic [1:0]        mem_acc_size,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              insn_valid,
    output logic [DATA_W-1:0] insn,
    output logic [ADDR_W-1:0] insn_pc,
    output logic              proto_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              proto_err_q, proto_err_d;

    logic [CNT_W-1:0]  count_s;
    logic              rvalid_ok_s;
    logic              credit_ok_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] redirect_aligned_s;
    logic              unused_redirect_lsb_s;

    // Request, response and pop qualifiers. Requests are held off during
    // reset and while a redirect is being applied.
    always_comb begin
        redirect_aligned_s = {redirect_pc[ADDR_W-1:2], 2'b00};
        rvalid_ok_s        = mem_rvalid && (inflight_q != {CNT_W{1'b0}});
        credit_ok_s        = ({1'b0, count_s} + {1'b0, inflight_q}) < SUM_W'(DEPTH);
        mem_req            = reset_n && !redirect_valid && credit_ok_s;
        accept_s           = mem_req && !mem_busy;
        push_s             = rvalid_ok_s && (drop_q == {CNT_W{1'b0}}) && !redirect_valid;
        pop_s              = insn_valid && !stall && !redirect_valid;
    end

    // Next-state for PCs, outstanding/drop counters and the sticky error.
    always_comb begin
        pc_d        = pc_q;
        out_pc_d    = out_pc_q;
        inflight_d  = inflight_q;
        drop_d      = drop_q;
        proto_err_d = proto_err_q || (mem_rvalid && (inflight_q == {CNT_W{1'b0}}));
        case ({accept_s, rvalid_ok_s})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
        if (redirect_valid) begin
            // No request is accepted here, so inflight_d already excludes any
            // response arriving this cycle: everything still outstanding is stale.
            pc_d     = redirect_aligned_s;
            out_pc_d = redirect_aligned_s;
            drop_d   = inflight_d;
        end else begin
            if (accept_s) begin
                pc_d = pc_q + ADDR_W'(WORD_BYTES);
            end else begin
                pc_d = pc_q;
            end
            if (pop_s) begin
                out_pc_d = out_pc_q + ADDR_W'(WORD_BYTES);
            end else begin
                out_pc_d = out_pc_q;
            end
            if (rvalid_ok_s && (drop_q != {CNT_W{1'b0}})) begin
                drop_d = drop_q - CNT_W'(1);
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= START_ADDRESS;
            out_pc_q    <= START_ADDRESS;
            inflight_q  <= {CNT_W{1'b0}};
            drop_q      <= {CNT_W{1'b0}};
            proto_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            out_pc_q    <= out_pc_d;
            inflight_q  <= inflight_d;
            drop_q      <= drop_d;
            proto_err_q <= proto_err_d;
        end
    end

    fetch_queue #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (mem_rdata),
        .pop       (pop_s),
        .head_data (insn),
        .count     (count_s)
    );

    assign mem_addr              = pc_q;
    assign mem_acc_size          = ACC_SIZE_WORD;
    assign insn_valid            = (count_s != {CNT_W{1'b0}});
    assign insn_pc               = out_pc_q;
    assign proto_err             = proto_err_q;
    assign unused_redirect_lsb_s = ^redirect_pc[1:0];

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a 1-cycle in-order memory model.
module tb_fetch_buffer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_busy = 1'b0;
    logic [1:0]  mem_acc_size;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        proto_err;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] pend [$];
    logic        resp_en = 1'b0;
    logic        last_acc = 1'b0;
    logic [31:0] last_acc_addr = 32'h0;

    fetch_buffer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .mem_addr       (mem_addr),
        .mem_req        (mem_req),
        .mem_busy       (mem_busy),
        .mem_acc_size   (mem_acc_size),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .insn_valid     (insn_valid),
        .insn           (insn),
        .insn_pc        (insn_pc),
        .proto_err      (proto_err)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // One clock: record acceptance, cross the edge, present the next response.
    task automatic step();
        #1;
        last_acc      = mem_req && !mem_busy;
        last_acc_addr = mem_addr;
        if (last_acc) pend.push_back(mem_addr);
        @(posedge clock);
        @(negedge clock);
        if (resp_en && pend.size() > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = data_of(pend.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        mem_busy = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; resp_en = 1'b0;
        pend.delete();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_busy = 1'b0; mem_rvalid = 1'b0; resp_en = 1'b0; pend.delete();
        @(negedge clock);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
        checks++; if (insn_valid !== 1'b0) begin failures++; $display("FAIL reset_insn_valid got=%0b exp=0", insn_valid); end
        checks++; if (insn !== 32'h0) begin failures++; $display("FAIL reset_insn got=%h exp=0", insn); end
        checks++; if (mem_addr !== 32'h8002_0000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=80020000", mem_addr); end
        checks++; if (insn_pc !== 32'h8002_0000) begin failures++; $display("FAIL reset_insn_pc got=%h exp=80020000", insn_pc); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto_err got=%0b exp=0", proto_err); end
        checks++; if (mem_acc_size !== 2'b00) begin failures++; $display("FAIL acc_size got=%b exp=00", mem_acc_size); end
        reset_n = 1'b1;
        step();
        checks++; if (last_acc !== 1'b1 || last_acc_addr !== 32'h8002_0000) begin
            failures++; $display("FAIL first_req acc=%0b addr=%h exp acc=1 addr=80020000", last_acc, last_acc_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_req;
        logic [31:0] exp_pc;
        int          n;
        do_reset();
        resp_en = 1'b1;
        exp_req = 32'h8002_0000;
        exp_pc  = 32'h8002_0000;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++; if (last_acc !== 1'b1 || last_acc_addr !== exp_req) begin
                failures++; $display("FAIL seq_addr acc=%0b addr=%h exp=%h", last_acc, last_acc_addr, exp_req); end
            exp_req = exp_req + 32'd4;
            if (insn_valid === 1'b1) begin
                checks++; if (insn_pc !== exp_pc || insn !== data_of(exp_pc)) begin
                    failures++; $display("FAIL seq_insn pc=%h insn=%h exp pc=%h insn=%h", insn_pc, insn, exp_pc, data_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                n++;
            end
        end
        checks++; if (n !== 11) begin failures++; $display("FAIL seq_count got=%0d exp=11", n); end
    endtask

    task automatic test_stall();
        int          acc_cnt;
        int          n;
        logic [31:0] exp_pc;
        do_reset();
        resp_en = 1'b1;
        stall = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_acc === 1'b1) acc_cnt++;
            if (i >= 1) begin
                checks++; if (insn_valid !== 1'b1 || insn_pc !== 32'h8002_0000 || insn !== data_of(32'h8002_0000)) begin
                    failures++; $display("FAIL stall_hold valid=%0b pc=%h insn=%h exp pc=80020000", insn_valid, insn_pc, insn); end
            end
        end
        checks++; if (acc_cnt !== 4) begin failures++; $display("FAIL stall_req_count got=%0d exp=4", acc_cnt); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL stall_mem_req got=%0b exp=0", mem_req); end
        stall = 1'b0;
        exp_pc = 32'h8002_0000;
        n = 0;
        for (int i = 0; i < 12 && n < 6; i++) begin
            if (insn_valid === 1'b1) begin
                checks++; if (insn_pc !== exp_pc || insn !== data_of(exp_pc)) begin
                    failures++; $display("FAIL stall_resume pc=%h insn=%h exp pc=%h", insn_pc, insn, exp_pc); end
                exp_pc = exp_pc + 32'd4;
                n++;
            end
            step();
        end
        checks++; if (n !== 6) begin failures++; $display("FAIL stall_resume_count got=%0d exp=6", n); end
    endtask

    task automatic test_redirect();
        logic found;
        do_reset();
        resp_en = 1'b0;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8002_0103;
        step();
        redirect_valid = 1'b0;
        checks++; if (last_acc !== 1'b0) begin failures++; $display("FAIL redir_no_req got=%0b exp=0", last_acc); end
        checks++; if (mem_addr !== 32'h8002_0100) begin failures++; $display("FAIL redir_addr got=%h exp=80020100", mem_addr); end
        checks++; if (insn_valid !== 1'b0 || insn_pc !== 32'h8002_0100) begin
            failures++; $display("FAIL redir_out valid=%0b pc=%h exp valid=0 pc=80020100", insn_valid, insn_pc); end
        resp_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (insn_valid === 1'b1) begin
                found = 1'b1;
                checks++; if (insn_pc !== 32'h8002_0100 || insn !== data_of(32'h8002_0100)) begin
                    failures++; $display("FAIL redir_first pc=%h insn=%h exp pc=80020100 insn=%h", insn_pc, insn, data_of(32'h8002_0100)); end
            end else begin
                step();
            end
        end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL redir_timeout got=0 exp=1"); end
    endtask

    task automatic test_back_to_back();
        logic found;
        do_reset();
        resp_en = 1'b0;
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8003_0008;
        resp_en        = 1'b1;
        step();
        checks++; if (last_acc !== 1'b0 || mem_addr !== 32'h8003_0008) begin
            failures++; $display("FAIL b2b_first acc=%0b addr=%h exp acc=0 addr=80030008", last_acc, mem_addr); end
        redirect_pc = 32'h8004_0011;
        step();
        redirect_valid = 1'b0;
        checks++; if (mem_addr !== 32'h8004_0010 || insn_pc !== 32'h8004_0010) begin
            failures++; $display("FAIL b2b_second addr=%h pc=%h exp=80040010", mem_addr, insn_pc); end
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (insn_valid === 1'b1) begin
                found = 1'b1;
                checks++; if (insn_pc !== 32'h8004_0010 || insn !== data_of(32'h8004_0010)) begin
                    failures++; $display("FAIL b2b_insn pc=%h insn=%h exp pc=80040010 insn=%h", insn_pc, insn, data_of(32'h8004_0010)); end
            end else begin
                step();
            end
        end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL b2b_timeout got=0 exp=1"); end
    endtask

    task automatic test_busy();
        do_reset();
        resp_en  = 1'b1;
        mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (last_acc !== 1'b0 || mem_addr !== 32'h8002_0000 || insn_valid !== 1'b0) begin
                failures++; $display("FAIL busy_hold acc=%0b addr=%h valid=%0b exp acc=0 addr=80020000 valid=0", last_acc, mem_addr, insn_valid); end
        end
        mem_busy = 1'b0;
        step();
        checks++; if (last_acc !== 1'b1 || last_acc_addr !== 32'h8002_0000 || mem_addr !== 32'h8002_0004) begin
            failures++; $display("FAIL busy_release acc=%0b acc_addr=%h addr=%h exp 1/80020000/80020004", last_acc, last_acc_addr, mem_addr); end
    endtask

    task automatic test_proto_err();
        do_reset();
        mem_busy   = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        step();
        checks++; if (proto_err !== 1'b1 || insn_valid !== 1'b0) begin
            failures++; $display("FAIL proto_set err=%0b valid=%0b exp err=1 valid=0", proto_err, insn_valid); end
        step();
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_sticky got=%0b exp=1", proto_err); end
        mem_busy = 1'b0;
        resp_en  = 1'b1;
        stall    = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++; if (insn_valid !== 1'b1) begin failures++; $display("FAIL midstream_busy got=%0b exp=1", insn_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || insn_valid !== 1'b0 || insn !== 32'h0) begin
            failures++; $display("FAIL async_reset_a req=%0b valid=%0b insn=%h exp 0/0/0", mem_req, insn_valid, insn); end
        checks++; if (mem_addr !== 32'h8002_0000 || insn_pc !== 32'h8002_0000 || proto_err !== 1'b0) begin
            failures++; $display("FAIL async_reset_b addr=%h pc=%h err=%0b exp 80020000/80020000/0", mem_addr, insn_pc, proto_err); end
        pend.delete();
        resp_en    = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge clock);
        reset_n    = 1'b1;
        mem_busy   = 1'b1;
        mem_rvalid = 1'b1;
        step();
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL stale_resp_err got=%0b exp=1", proto_err); end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        checks++; if (mem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_load got=%h exp=fffffffc", mem_addr); end
        step();
        checks++; if (last_acc !== 1'b1 || last_acc_addr !== 32'hFFFF_FFFC || mem_addr !== 32'h0) begin
            failures++; $display("FAIL wrap_next acc=%0b acc_addr=%h addr=%h exp 1/fffffffc/00000000", last_acc, last_acc_addr, mem_addr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_busy();
        test_proto_err();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter START_ADDRESS, default 32'h80020000: PC value after reset.
REQ-002 Parameter DATA_W, default 32: instruction width, bits.
REQ-003 Parameter ADDR_W, default 32: PC/address width, bits.
REQ-004 Parameter DEPTH, default 4 (legal 2..16): instruction queue entries; also max requests in flight plus queued.
REQ-005 clock  in  1  single clock; all state updates on posedge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 mem_addr  out  ADDR_W  fetch address (current PC).
REQ-008 mem_req  out  1  fetch request valid.
REQ-009 mem_busy  in  1  memory cannot accept; request accepted only when mem_req=1 and mem_busy=0.
REQ-010 mem_acc_size  out  2  access size, constant 2'b00 (one word).
REQ-011 mem_rvalid  in  1  read data valid; responses return in request order.
REQ-012 mem_rdata  in  DATA_W  read data.
REQ-013 redirect_valid  in  1  branch/jump redirect, one-cycle pulse.
REQ-014 redirect_pc  in  ADDR_W  redirect target.
REQ-015 stall  in  1  consumer (decode) cannot accept this cycle.
REQ-016 insn_valid  out  1  queue head valid.
REQ-017 insn  out  DATA_W  queue head instruction.
REQ-018 insn_pc  out  ADDR_W  address of queue head instruction.
REQ-019 proto_err  out  1  sticky: mem_rvalid seen with nothing in flight.

Function
REQ-020 mem_addr SHALL equal pc register; mem_req = !redirect_valid && (count + inflight < DEPTH).
REQ-021 On accepted request pc SHALL advance by 4 (modulo 2^ADDR_W, wrap silently) and inflight SHALL increment.
REQ-022 On mem_rvalid: if drop_cnt > 0, data SHALL be discarded and drop_cnt decremented; else data pushed to queue tail; either way inflight decrements.
REQ-023 Same-cycle accept and response SHALL leave inflight unchanged.
REQ-024 insn_valid = (count > 0); insn = head entry; insn_pc = out_pc register; combinational from registers, zero added latency.
REQ-025 Pop occurs when insn_valid=1 and stall=0; out_pc then advances by 4.
REQ-026 Same-cycle push and pop SHALL leave count unchanged; push never occurs at count=DEPTH (credit rule REQ-020).
REQ-027 Minimum latency: memory response in cycle N SHALL appear on insn/insn_valid in cycle N+1.
REQ-028 Redirect has highest priority: queue emptied (count=0), pc and out_pc loaded with {redirect_pc[ADDR_W-1:2],2'b00}, no request issued, pop ignored.
REQ-029 On redirect, drop_cnt SHALL load inflight minus any response arriving that cycle; that response is discarded regardless.
REQ-030 Back-to-back redirects SHALL each reload pc/out_pc; drop_cnt accumulates correctly (last redirect wins address).
REQ-031 mem_rvalid with inflight=0 SHALL be ignored and set proto_err until reset.
REQ-032 stall held indefinitely SHALL hold insn/insn_pc stable; fetching continues until credits exhausted.

Reset
REQ-033 reset_n=0 SHALL immediately set pc=out_pc=START_ADDRESS, count=inflight=drop_cnt=0, proto_err=0, mem_req=0, insn_valid=0, insn=0.
REQ-034 Reset mid-operation SHALL abandon in-flight requests; responses after reset release count as proto_err cases.
REQ-035 First request SHALL be issued the first clock after reset_n deasserts.

Structure
REQ-036 Shared package holds START_ADDRESS default, word size constant 4, ACC_SIZE_WORD = 2'b00.
REQ-037 Queue SHALL be a sub-module fetch_queue (DEPTH x DATA_W circular buffer, head/tail pointers, count, flush input).

Verification
REQ-038 Reset, mem_busy=0, 1-cycle memory: mem_addr sequence 80020000, 80020004, 80020008...; insn_pc matches data order.
REQ-039 stall=1 for 10 cycles with DEPTH=4: exactly 4 requests total, mem_req=0 thereafter, insn stable; release -> resumes.
REQ-040 Redirect to 80020103 with 2 in flight: next mem_addr 80020100, two subsequent responses dropped, first insn_pc 80020100.
REQ-041 mem_busy=1 for 5 cycles: mem_addr held at same PC, no pc advance, no output change beyond queued data.
REQ-042 mem_rvalid with nothing outstanding -> proto_err=1, count unchanged; reset_n pulse mid-stream -> all outputs to REQ-033 values asynchronously.
REQ-043 pc at FFFFFFFC accepted -> next mem_addr 00000000.
